// File: rtl/sram_lane_bank_if.sv
// Access bus of the lane-organised SRAM bank: chip/write selects, per-lane
// write mask, write/read addresses and the registered read return.
interface sram_lane_bank_if #(
    parameter int LANE_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 6
);
    localparam int W = LANE_WIDTH * LANES;

    logic                  csb;
    logic                  wsb;
    logic [LANES-1:0]      wmask;
    logic [W-1:0]          wdata;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [W-1:0]          rdata;
    logic                  rvalid;
    logic                  init_busy;

    modport master (
        output csb, wsb, wmask, wdata, waddr, raddr,
        input  rdata, rvalid, init_busy
    );

    modport slave (
        input  csb, wsb, wmask, wdata, waddr, raddr,
        output rdata, rvalid, init_busy
    );
endinterface

// File: rtl/sram_lane_bank.sv
// Single-clock lane-masked SRAM bank with a post-reset zeroing sequence,
// 1- or 2-cycle pipelined reads and optional read-during-write bypass.
module sram_lane_bank #(
    parameter int LANE_WIDTH     = 16,
    parameter int LANES          = 8,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = 6,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic             clk,
    input logic             rst,
    sram_lane_bank_if.slave bus
);
    localparam int W     = LANE_WIDTH * LANES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST    = IDX_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             init_busy_q, init_busy_d;
    logic             rvalid_q, rvalid_d;
    logic [W-1:0]     rdata_q, rdata_d;
    logic [W-1:0]     mem_q [DEPTH];

    logic             waddr_ok, raddr_ok;
    logic             wr_en, rd_acc;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [LANES-1:0] wr_lanes;
    logic [W-1:0]     wr_data, rd_word;
    logic             out_v;
    logic [W-1:0]     out_d;

    assign waddr_ok = {1'b0, bus.waddr} < DEPTH_X;
    assign raddr_ok = {1'b0, bus.raddr} < DEPTH_X;
    assign rd_idx   = bus.raddr[IDX_W-1:0];

    // Next-state, memory write port selection and read word (with bypass merge)
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_d = init_busy_q;
        wr_en       = 1'b0;
        wr_idx      = bus.waddr[IDX_W-1:0];
        wr_lanes    = bus.wmask;
        wr_data     = bus.wdata;
        rd_acc      = 1'b0;
        rd_word     = '0;
        case (state_q)
            S_CLEAR: begin
                wr_en    = 1'b1;
                wr_idx   = cnt_q;
                wr_lanes = '1;
                wr_data  = '0;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = S_READY;
                    init_busy_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: begin
                wr_en  = !bus.csb && !bus.wsb && waddr_ok;
                rd_acc = !bus.csb;
            end
        endcase
        if (rst) begin
            wr_en  = 1'b0;
            rd_acc = 1'b0;
        end
        if (rd_acc && raddr_ok) begin
            rd_word = mem_q[rd_idx];
            // Same-edge write to the read address: masked lanes see new data
            if (BYPASS != 0 && wr_en && bus.waddr == bus.raddr) begin
                for (int i = 0; i < LANES; i++) begin
                    if (bus.wmask[i]) begin
                        rd_word[i*LANE_WIDTH +: LANE_WIDTH] = bus.wdata[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // Clear/ready FSM with registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            init_busy_q <= (RST_STATE == S_CLEAR);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Storage array: per-lane masked write, no reset (cleared by the FSM)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lanes[i]) begin
                    mem_q[wr_idx][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic         p_v_q, p_v_d;
            logic [W-1:0] p_d_q, p_d_d;

            // Extra read stage ahead of the output register
            always_comb begin
                p_v_d = rd_acc;
                p_d_d = rd_acc ? rd_word : p_d_q;
            end

            // Extra read stage registers, flushed by reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    p_v_q <= 1'b0;
                    p_d_q <= '0;
                end else begin
                    p_v_q <= p_v_d;
                    p_d_q <= p_d_d;
                end
            end

            assign out_v = p_v_q;
            assign out_d = p_d_q;
        end else begin : g_lat1
            assign out_v = rd_acc;
            assign out_d = rd_word;
        end
    endgenerate

    // Output register: data only moves when a valid leaves the pipeline
    always_comb begin
        rvalid_d = out_v;
        rdata_d  = out_v ? out_d : rdata_q;
    end

    // Read return registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.init_busy = init_busy_q;
endmodule

// File: tb/tb_sram_lane_bank.sv
// Drives two bank configurations with the same stimulus and scores each
// against its own behavioural memory model and expected-read queue.
//   dut0: DEPTH 16, latency 1, no bypass
//   dut1: DEPTH 12, latency 2, bypass
module tb_sram_lane_bank;
    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    localparam int DEPTH_K [2] = '{16, 12};
    localparam int LAT_K   [2] = '{1, 2};
    localparam int BYP_K   [2] = '{0, 1};

    logic         clk = 1'b0;
    logic         tb_rst, tb_csb, tb_wsb;
    logic [7:0]   tb_wmask;
    logic [127:0] tb_wdata;
    logic [5:0]   tb_waddr, tb_raddr;

    logic [1:0]   rv, ib;
    logic [127:0] rd [2];

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           clr_left [2];
    logic [127:0] exp_rd   [2];
    logic [127:0] mm       [2][16];
    exp_t         q0 [$];
    exp_t         q1 [$];

    always #5 clk = ~clk;

    sram_lane_bank_if #(.LANE_WIDTH(16), .LANES(8), .ADDR_WIDTH(6)) bus0 ();
    sram_lane_bank_if #(.LANE_WIDTH(16), .LANES(8), .ADDR_WIDTH(6)) bus1 ();

    assign bus0.csb = tb_csb;   assign bus1.csb = tb_csb;
    assign bus0.wsb = tb_wsb;   assign bus1.wsb = tb_wsb;
    assign bus0.wmask = tb_wmask; assign bus1.wmask = tb_wmask;
    assign bus0.wdata = tb_wdata; assign bus1.wdata = tb_wdata;
    assign bus0.waddr = tb_waddr; assign bus1.waddr = tb_waddr;
    assign bus0.raddr = tb_raddr; assign bus1.raddr = tb_raddr;

    assign rv[0] = bus0.rvalid;    assign rv[1] = bus1.rvalid;
    assign ib[0] = bus0.init_busy; assign ib[1] = bus1.init_busy;
    assign rd[0] = bus0.rdata;     assign rd[1] = bus1.rdata;

    sram_lane_bank #(
        .LANE_WIDTH(16), .LANES(8), .DEPTH(16), .ADDR_WIDTH(6),
        .READ_LATENCY(1), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk (clk),
        .rst (tb_rst),
        .bus (bus0)
    );

    sram_lane_bank #(
        .LANE_WIDTH(16), .LANES(8), .DEPTH(12), .ADDR_WIDTH(6),
        .READ_LATENCY(2), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk (clk),
        .rst (tb_rst),
        .bus (bus1)
    );

    task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    // One clock of stimulus: drive, update models at the edge, compare at negedge
    task automatic step(input logic r, input logic c, input logic w, input logic [7:0] m,
                        input logic [127:0] d, input logic [5:0] wa, input logic [5:0] ra);
        exp_t         e;
        logic [127:0] word;
        logic         wacc;
        logic         ev;
        tb_rst = r; tb_csb = c; tb_wsb = w; tb_wmask = m;
        tb_wdata = d; tb_waddr = wa; tb_raddr = ra;
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                clr_left[k] = DEPTH_K[k];
                exp_rd[k]   = '0;
                for (int a = 0; a < 16; a++) mm[k][a] = '0;
                if (k == 0) q0.delete(); else q1.delete();
            end else if (clr_left[k] != 0) begin
                clr_left[k]--;
            end else begin
                wacc = !c && !w && (int'(wa) < DEPTH_K[k]);
                if (!c) begin
                    word = '0;
                    if (int'(ra) < DEPTH_K[k]) word = mm[k][ra[3:0]];
                    if (BYP_K[k] != 0 && wacc && wa == ra) begin
                        for (int i = 0; i < 8; i++)
                            if (m[i]) word[i*16 +: 16] = d[i*16 +: 16];
                    end
                    e.data = word;
                    e.due  = cyc + LAT_K[k] - 1;
                    if (k == 0) q0.push_back(e); else q1.push_back(e);
                end
                if (wacc) begin
                    for (int i = 0; i < 8; i++)
                        if (m[i]) mm[k][wa[3:0]][i*16 +: 16] = d[i*16 +: 16];
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            ev = 1'b0;
            if (k == 0) begin
                if (q0.size() > 0 && q0[0].due == cyc) begin
                    e = q0.pop_front(); ev = 1'b1; exp_rd[k] = e.data;
                end
            end else begin
                if (q1.size() > 0 && q1[0].due == cyc) begin
                    e = q1.pop_front(); ev = 1'b1; exp_rd[k] = e.data;
                end
            end
            chk_eq($sformatf("rvalid%0d", k), {127'd0, rv[k]}, {127'd0, ev});
            chk_eq($sformatf("rdata%0d", k), rd[k], exp_rd[k]);
            chk_eq($sformatf("init_busy%0d", k), {127'd0, ib[k]}, {127'd0, clr_left[k] != 0});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b1, 8'h00, '0, 6'd0, 6'd0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [127:0] d, input logic [7:0] m);
        step(1'b0, 1'b0, 1'b0, m, d, a, a);
    endtask

    task automatic rd_req(input logic [5:0] a);
        step(1'b0, 1'b0, 1'b1, 8'h00, '0, 6'd0, a);
    endtask

    // Idle until the 16-deep bank leaves its clear sequence; the length is checked
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        do begin
            idle();
            n++;
        end while (ib[0] && n < 40);
        chk_eq(tag, 128'(n), 128'd16);
    endtask

    initial begin
        logic [127:0] rnd_d;
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = 0;
            exp_rd[k]   = '0;
        end

        step(1'b1, 1'b1, 1'b1, 8'h00, '0, 6'd0, 6'd0);
        step(1'b1, 1'b0, 1'b0, 8'hFF, '1, 6'd0, 6'd0);
        wait_clear("clear_len_init");

        for (int a = 0; a < 16; a++) wr(6'(a), '1, 8'hFF);
        for (int a = 0; a < 16; a++) rd_req(6'(a));

        step(1'b1, 1'b1, 1'b1, 8'h00, '0, 6'd0, 6'd0);
        wait_clear("clear_len_post");
        for (int a = 0; a < 16; a++) rd_req(6'(a));

        wr(6'd3, {8{16'h1111}}, 8'hFF);
        wr(6'd3, {8{16'hAAAA}}, 8'h0F);
        rd_req(6'd3);

        step(1'b0, 1'b0, 1'b0, 8'hFF, {8{16'h1234}}, 6'd5, 6'd5);
        rd_req(6'd5);

        wr(6'd0, {8{16'hC0C0}}, 8'hFF);
        wr(6'd1, {8{16'hC1C1}}, 8'hFF);
        wr(6'd2, {8{16'hC2C2}}, 8'hFF);
        rd_req(6'd0); rd_req(6'd1); rd_req(6'd2);
        idle(); idle(); idle();

        wr(6'd13, '1, 8'hFF);
        rd_req(6'd13);
        for (int a = 0; a < 12; a++) rd_req(6'(a));
        idle(); idle();

        rd_req(6'd1);
        step(1'b1, 1'b0, 1'b1, 8'h00, '0, 6'd0, 6'd2);
        wait_clear("clear_len_mid");
        rd_req(6'd1);

        for (int n = 0; n < 300; n++) begin
            rnd_d = {$urandom(), $urandom(), $urandom(), $urandom()};
            step(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), rnd_d,
                 6'($urandom_range(0, 17)), 6'($urandom_range(0, 17)));
        end
        for (int n = 0; n < 4; n++) idle();
        chk_eq("sb_drain", 128'(q0.size() + q1.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
